// File: rtl/fft_frame_loader.sv
// -----------------------------------------------------------------------------
// fft_frame_loader
//
// Serial-to-parallel ping-pong frame buffer feeding the bit-reversal scrambler
// in the FFT input path. One WIDTH-bit sample is accepted per cycle over a
// valid/ready handshake. SAMPLES consecutive samples are assembled into a frame
// that is presented, in arrival order, as a parallel unpacked array. Two banks
// let one frame fill while the other waits for the consumer.
//
// Optional feature (compile-time macro): FFT_LOADER_PAD_EN
//   When defined, adds the in_last port. An accept with in_last = 1 closes a
//   short frame: the sample is written at the current slot, the remaining
//   slots are zero-filled in the same cycle, and the frame completes.
//   When undefined, frames complete only on the SAMPLES-th accept.
//
// Parameters:
//   SAMPLES     samples per frame (power of two, >= 2)
//   WIDTH       bits per sample
//   IDX_W       width of the fill index ($clog2(SAMPLES))
//
// Ports:
//   clk         clock; all state updates on the rising edge
//   rst         synchronous, active-high reset
//   in_valid    in_data is valid this cycle
//   in_ready    loader can accept a sample this cycle
//   in_data     sample value
//   in_last     (FFT_LOADER_PAD_EN only) final sample of a short frame
//   frame_valid frame_data holds a complete frame
//   frame_ready consumer takes the frame this cycle
//   frame_data  frame; element k = k-th sample accepted into that frame
// -----------------------------------------------------------------------------
module fft_frame_loader #(
  parameter int SAMPLES = 8,
  parameter int WIDTH   = 3,
  parameter int IDX_W   = $clog2(SAMPLES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
`ifdef FFT_LOADER_PAD_EN
  input  logic             in_last,
`endif
  output logic             frame_valid,
  input  logic             frame_ready,
  output logic [WIDTH-1:0] frame_data [SAMPLES-1:0]
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SAMPLES - 1);

  // Per-bank lifecycle: EMPTY -> FILLING -> FULL -> EMPTY.
  typedef enum logic [1:0] {
    BANK_EMPTY   = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_t;

  bank_state_t      state      [2];
  bank_state_t      state_next [2];

  logic [WIDTH-1:0] bank [2][SAMPLES];

  logic             wb;
  logic             wb_next;
  logic             rb;
  logic             rb_next;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_next;

  logic [1:0]       full;
  logic             accept;
  logic             take;
  logic             last_flag;
  logic             complete;
  logic             pad_fill;

  // Handshake decode: bank occupancy, ready/valid and frame-completion flags.
  always_comb begin
    full = 2'b00;
    for (int b = 0; b < 2; b++) begin
      full[b] = (state[b] == BANK_FULL);
    end
    in_ready    = ~full[wb];
    frame_valid = full[rb];
    accept      = in_valid & in_ready;
    take        = frame_valid & frame_ready;
`ifdef FFT_LOADER_PAD_EN
    last_flag   = in_last;
`else
    last_flag   = 1'b0;
`endif
    // in_last on the final slot is harmless: the frame completes either way.
    complete    = accept & ((idx == LAST_IDX) | last_flag);
    pad_fill    = accept & last_flag;
  end

  // Pointer next-state: fill index, write bank and read bank.
  always_comb begin
    wb_next  = wb;
    rb_next  = rb;
    idx_next = idx;
    if (accept) begin
      if (complete) begin
        wb_next  = ~wb;
        idx_next = IDX_W'(0);
      end else begin
        idx_next = idx + IDX_W'(1);
      end
    end else begin
      idx_next = idx;
    end
    if (take) begin
      rb_next = ~rb;
    end else begin
      rb_next = rb;
    end
  end

  // Per-bank state next-state. A completing write and a take can occur in the
  // same cycle; they always address different banks because the write needs
  // the write bank not full and the take needs the read bank full.
  always_comb begin
    for (int b = 0; b < 2; b++) begin
      state_next[b] = state[b];
      case (state[b])
        BANK_EMPTY: begin
          if (accept && (wb == 1'(b))) begin
            state_next[b] = complete ? BANK_FULL : BANK_FILLING;
          end else begin
            state_next[b] = BANK_EMPTY;
          end
        end
        BANK_FILLING: begin
          if (complete && (wb == 1'(b))) begin
            state_next[b] = BANK_FULL;
          end else begin
            state_next[b] = BANK_FILLING;
          end
        end
        BANK_FULL: begin
          if (take && (rb == 1'(b))) begin
            state_next[b] = BANK_EMPTY;
          end else begin
            state_next[b] = BANK_FULL;
          end
        end
        default: begin
          state_next[b] = BANK_EMPTY;
        end
      endcase
    end
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb  <= 1'b0;
      rb  <= 1'b0;
      idx <= IDX_W'(0);
      for (int b = 0; b < 2; b++) begin
        state[b] <= BANK_EMPTY;
      end
    end else begin
      wb  <= wb_next;
      rb  <= rb_next;
      idx <= idx_next;
      for (int b = 0; b < 2; b++) begin
        state[b] <= state_next[b];
      end
    end
  end

  // Sample storage. Only the write bank is touched; taking a frame leaves its
  // contents in place. With padding, slots after the current one are cleared
  // in the same cycle as the closing sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < SAMPLES; k++) begin
          bank[b][k] <= WIDTH'(0);
        end
      end
    end else if (accept) begin
      for (int k = 0; k < SAMPLES; k++) begin
        if (IDX_W'(k) == idx) begin
          bank[wb][k] <= in_data;
        end else if (pad_fill && (IDX_W'(k) > idx)) begin
          bank[wb][k] <= WIDTH'(0);
        end
      end
    end
  end

  // Frame output: combinational mux of the read bank registers, so the data
  // stays stable while a frame waits for the consumer.
  always_comb begin
    for (int k = 0; k < SAMPLES; k++) begin
      frame_data[k] = bank[rb][k];
    end
  end

endmodule

// File: tb/tb_fft_frame_loader.sv
module tb_fft_frame_loader;

  localparam int SAMPLES = 8;
  localparam int WIDTH   = 3;
`ifdef FFT_LOADER_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  typedef logic [SAMPLES*WIDTH-1:0] flat_t;

  typedef struct {
    logic             v;
    logic [WIDTH-1:0] d;
    logic             fr;
    logic             exp_ready;
    logic             exp_fvalid;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             frame_valid;
  logic             frame_ready;
  logic [WIDTH-1:0] frame_data [SAMPLES-1:0];

  always #5 clk = ~clk;

  fft_frame_loader #(.SAMPLES(SAMPLES), .WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
`ifdef FFT_LOADER_PAD_EN
    .in_last     (in_last),
`endif
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_data  (frame_data)
  );

  // Scoreboard: frames the bench expects to be waiting, oldest first.
  flat_t            exp_q [$];
  logic [WIDTH-1:0] cur [SAMPLES];
  int               cur_idx = 0;
  int               taken   = 0;
  int               errors  = 0;
  int               checks  = 0;
  vec_t             tbl [29];

  function automatic flat_t pack_dut();
    flat_t f;
    for (int k = 0; k < SAMPLES; k++) f[k*WIDTH +: WIDTH] = frame_data[k];
    return f;
  endfunction

  function automatic flat_t pack_cur();
    flat_t f;
    for (int k = 0; k < SAMPLES; k++) f[k*WIDTH +: WIDTH] = cur[k];
    return f;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic fr, input logic l);
    in_valid    = v;
    in_data     = d;
    frame_ready = fr;
    in_last     = l;
  endtask

  // Compare outputs against the model, then advance one clock and update it.
  task automatic cycle();
    bit               m_ready;
    bit               m_valid;
    bit               acc;
    bit               tk;
    logic [WIDTH-1:0] d;
    logic             l;
    flat_t            dropped;
    m_ready = (exp_q.size() < 2);
    m_valid = (exp_q.size() > 0);
    check("in_ready", in_ready, m_ready);
    check("frame_valid", frame_valid, m_valid);
    if (m_valid) check("frame_data", pack_dut(), exp_q[0]);
    acc = in_valid && m_ready;
    tk  = frame_ready && m_valid;
    d   = in_data;
    l   = in_last;
    @(posedge clk);
    #1;
    if (tk) begin
      dropped = exp_q.pop_front();
      taken++;
    end
    if (acc) begin
      cur[cur_idx] = d;
      if (cur_idx == SAMPLES - 1 || (PAD && l === 1'b1)) begin
        for (int k = cur_idx + 1; k < SAMPLES; k++) cur[k] = '0;
        exp_q.push_back(pack_cur());
        cur_idx = 0;
      end else begin
        cur_idx++;
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(1'b0, 3'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    cur_idx = 0;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_frame_valid", frame_valid, 1'b0);
    check("rst_frame_data", pack_dut(), '0);
  endtask

  initial begin
    rst = 1'b1;
    drive(1'b0, 3'd0, 1'b0, 1'b0);
    for (int k = 0; k < SAMPLES; k++) cur[k] = '0;

    // Reset state.
    do_reset();

    // Single frame, consumer stalled.
    for (int i = 0; i < SAMPLES; i++) begin
      drive(1'b1, WIDTH'(i), 1'b0, 1'b0);
      cycle();
    end
    drive(1'b0, 3'd0, 1'b0, 1'b0);
    check("single_valid", frame_valid, 1'b1);
    check("single_ready", in_ready, 1'b1);
    for (int k = 0; k < SAMPLES; k++) check($sformatf("single_fd%0d", k), frame_data[k], k);
    cycle();
    drive(1'b0, 3'd0, 1'b1, 1'b0);
    cycle();
    drive(1'b0, 3'd0, 1'b0, 1'b0);
    cycle();

    // Backpressure table: two full banks, held 17th sample, single take.
    for (int i = 0; i < 29; i++) begin
      tbl[i].v = 1'b1; tbl[i].d = 3'd5; tbl[i].fr = 1'b0;
      tbl[i].exp_ready = 1'b1; tbl[i].exp_fvalid = 1'b1;
      if (i < 16) begin
        tbl[i].d = (i < 8) ? WIDTH'(7 - i) : WIDTH'(i - 8);
        tbl[i].exp_fvalid = (i >= 8);
      end else if (i < 19) begin
        tbl[i].exp_ready = 1'b0;
        tbl[i].fr = (i == 18);
      end else if (i >= 20 && i <= 26) begin
        tbl[i].d = WIDTH'(i - 19);
        tbl[i].fr = (i == 20);
        tbl[i].exp_fvalid = (i == 20);
      end else if (i == 27) begin
        tbl[i].v = 1'b0; tbl[i].d = 3'd0; tbl[i].fr = 1'b1;
      end else if (i == 28) begin
        tbl[i].v = 1'b0; tbl[i].d = 3'd0; tbl[i].exp_fvalid = 1'b0;
      end
    end
    do_reset();
    for (int i = 0; i < 29; i++) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].fr, 1'b0);
      check($sformatf("bp_ready_%0d", i), in_ready, tbl[i].exp_ready);
      check($sformatf("bp_fvalid_%0d", i), frame_valid, tbl[i].exp_fvalid);
      cycle();
    end

    // Streaming with the consumer always ready.
    do_reset();
    taken = 0;
    for (int i = 0; i < 64; i++) begin
      drive(1'b1, WIDTH'(i % 8), 1'b1, 1'b0);
      cycle();
    end
    drive(1'b0, 3'd0, 1'b1, 1'b0);
    cycle();
    cycle();
    check("stream_frames", taken, 8);

    // Reset in the middle of a fill.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'd3, 1'b0, 1'b0);
      cycle();
    end
    do_reset();
    for (int i = 0; i < SAMPLES; i++) begin
      drive(1'b1, WIDTH'((i + 1) % 8), 1'b0, 1'b0);
      cycle();
    end
    drive(1'b0, 3'd0, 1'b0, 1'b0);
    check("midrst_fd0", frame_data[0], 1);
    check("midrst_fd7", frame_data[7], 0);
    cycle();
    drive(1'b0, 3'd0, 1'b1, 1'b0);
    cycle();

`ifdef FFT_LOADER_PAD_EN
    // Short frame closed by in_last.
    do_reset();
    drive(1'b1, 3'd5, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 3'd6, 1'b0, 1'b1);
    cycle();
    drive(1'b0, 3'd0, 1'b0, 1'b0);
    check("pad_valid", frame_valid, 1'b1);
    check("pad_fd2", frame_data[2], 0);
    cycle();
    for (int i = 0; i < SAMPLES; i++) begin
      drive(1'b1, WIDTH'(7 - i), (i == 0), 1'b0);
      cycle();
    end
    drive(1'b0, 3'd0, 1'b1, 1'b0);
    cycle();
    drive(1'b0, 3'd0, 1'b0, 1'b0);
    cycle();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fft_frame_loader.md
# fft_frame_loader

Serial-to-parallel ping-pong frame buffer that sits directly upstream of the bit-reversal scrambler in the FFT input path. It accepts one WIDTH-bit sample per cycle over a valid/ready handshake and assembles SAMPLES consecutive samples into a frame. It presents each completed frame as a parallel unpacked array, in natural (arrival) order, to the scrambler's input_stream. Two banks let one frame fill while the other waits for the consumer.

## Interface

- SAMPLES, 8, samples per frame; power of two, ≥2
- WIDTH, 3, bits per sample
- IDX_W, $clog2(SAMPLES), width of the fill index
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  in_data is valid this cycle
- in_ready  output  1  loader can accept a sample this cycle
- in_data  input  WIDTH  sample value
- frame_valid  output  1  frame_data holds a complete frame
- frame_ready  input  1  consumer takes the frame this cycle
- frame_data  output  [WIDTH-1:0] x [SAMPLES-1:0] (unpacked)  frame; element k = k-th sample accepted into that frame
- in_last  input  1  present only with FFT_LOADER_PAD_EN; marks final sample of a short frame

## Operation

- State: bank[0..1][0..SAMPLES-1] sample registers; full[1:0]; wb (write bank); rb (read bank); idx (IDX_W-bit fill index).
- The accept condition is in_valid && in_ready. in_ready = !full[wb].
- On accept: bank[wb][idx] <= in_data.
  - If idx == SAMPLES-1, then full[wb] <= 1, wb <= ~wb, idx <= 0.
  - Otherwise idx <= idx+1.
- frame_valid = full[rb]. frame_data = bank[rb], combinational mux from registers.
- Take condition is frame_valid && frame_ready. On take: full[rb] <= 0, rb <= ~rb. Bank contents are not cleared.
- Per-bank view: EMPTY → FILLING on first accept; FILLING → FULL on the SAMPLES-th accept; FULL → EMPTY on take.
- Simultaneous accept-completing-a-frame and take:
  - Always on different banks, since the write needs !full[wb] and the read needs full[rb].
  - Both updates apply in the same cycle.
- Both banks full:
  - in_ready = 0. Samples are held off, never dropped. idx stays at 0.
  - in_ready returns to 1 the cycle after a take.
- in_data is ignored when in_valid = 0 or in_ready = 0.
- frame_data must stay stable while frame_valid = 1 and frame_ready = 0.

## Timing

- Reset values:
  - in_ready = 1, frame_valid = 0, frame_data = all zeros.
  - All banks zero; full = 0; wb = rb = 0; idx = 0.
- Reset mid-operation discards partial and complete frames. The next accepted sample lands in bank 0 slot 0.
- Latency: the SAMPLES-th accept at edge N gives frame_valid = 1 in the cycle after edge N.
- frame_data is valid in that same cycle.
- Throughput: one sample per cycle sustained, provided each frame is taken within SAMPLES cycles of becoming valid.
- A take at edge M frees its bank. in_ready = 1 in the cycle after edge M when wb points to that bank.

## Configuration

- FFT_LOADER_PAD_EN defined:
  - Adds the in_last port.
  - An accept with in_last = 1 and idx < SAMPLES-1 writes the sample at idx and zero-fills slots idx+1..SAMPLES-1 in the same cycle.
  - That frame then completes exactly as a SAMPLES-th accept does (full, toggle wb, idx <= 0).
  - in_last on the SAMPLES-th accept has no extra effect.
- FFT_LOADER_PAD_EN undefined:
  - No in_last port.
  - Frames complete only on the SAMPLES-th accept.
  - A partial frame persists until filled or reset.

## Test plan

- Reset, then check outputs: in_ready = 1, frame_valid = 0, frame_data = {0,…,0}.
- Single frame:
  - Stimulus: frame_ready = 0; feed 0,1,…,7 back-to-back.
  - Required: frame_valid = 1 one cycle after the 8th accept; frame_data[k] = k; in_ready stays 1.
- Backpressure:
  - Stimulus: frame_ready = 0; feed 16 samples 7,6,…,0,0,1,…,7.
  - Required:
    - After the 16th accept, in_ready = 0 and a 17th sample (5) is held, not accepted.
    - Each 8-sample group matches its input order in frame_data.
  - Then pulse frame_ready for 1 cycle:
    - frame_data switches to the second frame.
    - in_ready = 1 the next cycle; sample 5 is accepted into slot 0.
- Streaming:
  - Stimulus: frame_ready = 1; in_valid = 1 continuously for 64 cycles with a counter mod 8.
  - Required: 8 frames, each {0..7}; in_ready never 0.
- Reset mid-fill:
  - Stimulus: feed 3,3,3; assert rst for 1 cycle; feed 1..8 (mod 8).
  - Required: first frame = {1,2,3,4,5,6,7,0}; no trace of the 3s.
- Pad (FFT_LOADER_PAD_EN):
  - Stimulus: feed 5,6 with in_last on the 6.
  - Required: frame_valid the next cycle; frame_data = {5,6,0,0,0,0,0,0}; the following frame starts at slot 0.
